// File: rtl/accum_calculator_if.sv
// Operation/result bundle between the board inputs, the accumulator and the display driver.
interface accum_calculator_if #(
   parameter int WIDTH = 4
);
   logic             push;
   logic [1:0]       op;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] acc;
   logic             neg;
   logic [WIDTH-1:0] mag;
   logic             led;
   logic             done;
   logic             hist_empty;
   logic             hist_full;

   modport master (
      output push, op, in,
      input  acc, neg, mag, led, done, hist_empty, hist_full
   );

   modport slave (
      input  push, op, in,
      output acc, neg, mag, led, done, hist_empty, hist_full
   );
endinterface

// File: rtl/accum_calculator.sv
// Signed push-button accumulator with overflow LED, sign/magnitude view and DEPTH-entry undo.
// Optional SATURATE_EN clamps overflowing add/sub results instead of wrapping.
module accum_calculator #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   accum_calculator_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   // History pointer steps around the ring of DEPTH slots.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return {PW{1'b0}};
      else                     return p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      if (p == {PW{1'b0}}) return PW'(DEPTH - 1);
      else                 return p - PW'(1);
   endfunction

   logic             s1_r, s2_r, p_r;
   logic [WIDTH-1:0] acc_r;
   logic             led_r;
   logic             done_r;
   logic [WIDTH-1:0] hist_r [DEPTH];
   logic [PW-1:0]    ptr_r;
   logic [CW-1:0]    cnt_r;

   logic             commit_s;
   logic [WIDTH-1:0] sum_s, diff_s;
   logic             ovf_add_s, ovf_sub_s;
   logic [WIDTH-1:0] acc_nxt_s;
   logic             led_nxt_s;
   logic             hist_push_s, hist_pop_s;
   logic [PW-1:0]    top_s;

   assign commit_s  = s2_r & ~p_r;
   assign sum_s     = acc_r + bus.in;
   assign diff_s    = acc_r - bus.in;
   assign ovf_add_s = (acc_r[WIDTH-1] == bus.in[WIDTH-1]) && (sum_s[WIDTH-1]  != acc_r[WIDTH-1]);
   assign ovf_sub_s = (acc_r[WIDTH-1] != bus.in[WIDTH-1]) && (diff_s[WIDTH-1] != acc_r[WIDTH-1]);
   assign top_s     = ptr_dec(ptr_r);

   // Next accumulator/LED value and history action for a commit edge.
   always_comb begin
      acc_nxt_s   = acc_r;
      led_nxt_s   = led_r;
      hist_push_s = 1'b0;
      hist_pop_s  = 1'b0;
      if (commit_s) begin
         case (bus.op)
            OP_ADD: begin
               hist_push_s = 1'b1;
               led_nxt_s   = ovf_add_s;
`ifdef SATURATE_EN
               // On overflow the true result has the sign of the old accumulator.
               acc_nxt_s   = ovf_add_s ? (acc_r[WIDTH-1] ? MIN_V : MAX_V) : sum_s;
`else
               acc_nxt_s   = sum_s;
`endif
            end
            OP_SUB: begin
               hist_push_s = 1'b1;
               led_nxt_s   = ovf_sub_s;
`ifdef SATURATE_EN
               acc_nxt_s   = ovf_sub_s ? (acc_r[WIDTH-1] ? MIN_V : MAX_V) : diff_s;
`else
               acc_nxt_s   = diff_s;
`endif
            end
            OP_CLR: begin
               hist_push_s = 1'b1;
               acc_nxt_s   = {WIDTH{1'b0}};
               led_nxt_s   = 1'b0;
            end
            OP_UND: begin
               if (cnt_r != {CW{1'b0}}) begin
                  hist_pop_s = 1'b1;
                  acc_nxt_s  = hist_r[top_s];
                  led_nxt_s  = 1'b0;
               end else begin
                  acc_nxt_s  = acc_r;
                  led_nxt_s  = led_r;
               end
            end
            default: begin
               acc_nxt_s = acc_r;
               led_nxt_s = led_r;
            end
         endcase
      end else begin
         acc_nxt_s = acc_r;
         led_nxt_s = led_r;
      end
   end

   // Push synchroniser, edge-detect flop and registered results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         p_r    <= 1'b0;
         acc_r  <= {WIDTH{1'b0}};
         led_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         s1_r   <= bus.push;
         s2_r   <= s1_r;
         p_r    <= s2_r;
         acc_r  <= acc_nxt_s;
         led_r  <= led_nxt_s;
         done_r <= commit_s;
      end
   end

   // Circular LIFO: a push into a full ring overwrites the oldest slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) hist_r[i] <= {WIDTH{1'b0}};
         ptr_r <= {PW{1'b0}};
         cnt_r <= {CW{1'b0}};
      end else if (hist_push_s) begin
         hist_r[ptr_r] <= acc_r;
         ptr_r         <= ptr_inc(ptr_r);
         if (cnt_r != CW'(DEPTH)) cnt_r <= cnt_r + CW'(1);
      end else if (hist_pop_s) begin
         ptr_r <= top_s;
         cnt_r <= cnt_r - CW'(1);
      end
   end

   assign bus.acc        = acc_r;
   assign bus.led        = led_r;
   assign bus.done       = done_r;
   assign bus.neg        = acc_r[WIDTH-1];
   assign bus.mag        = acc_r[WIDTH-1] ? (~acc_r + WIDTH'(1)) : acc_r;
   assign bus.hist_empty = (cnt_r == {CW{1'b0}});
   assign bus.hist_full  = (cnt_r == CW'(DEPTH));
endmodule

// File: tb/tb_accum_calculator.sv
// Self-checking bench for accum_calculator (WIDTH=4, DEPTH=4): directed scenarios plus random push traffic.
module tb_accum_calculator;
   localparam int W     = 4;
   localparam int D     = 4;
   localparam int MAXI  = 7;
   localparam int MINI  = -8;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   accum_calculator_if #(.WIDTH(W)) bus ();

   accum_calculator #(.WIDTH(W), .DEPTH(D)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Model state: signed accumulator value, LED, done, LIFO of old values.
   int m_acc;
   bit m_led, m_done;
   int hq[$];
   bit h1, h2, h3;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int wrap(input int t);
      if (t > MAXI)      return t - 16;
      else if (t < MINI) return t + 16;
      else               return t;
   endfunction

   function automatic void apply(input int t);
      bit ovf;
      ovf = (t > MAXI) || (t < MINI);
      m_led = ovf;
`ifdef SATURATE_EN
      if (ovf) m_acc = (t > 0) ? MAXI : MINI;
      else     m_acc = t;
`else
      m_acc = wrap(t);
`endif
   endfunction

   function automatic void hpush(input int v);
      hq.push_back(v);
      if (hq.size() > D) void'(hq.pop_front());
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_acc = 0; m_led = 0; m_done = 0;
         hq.delete();
         h1 = 0; h2 = 0; h3 = 0;
      end else begin
         int vin;
         vin = int'($signed(bus.in));
         m_done = 0;
         // Commit two edges after the first high sample following a low one.
         if (h2 && !h3) begin
            m_done = 1;
            case (bus.op)
               2'b00: begin hpush(m_acc); apply(m_acc + vin); end
               2'b01: begin hpush(m_acc); apply(m_acc - vin); end
               2'b10: begin hpush(m_acc); m_acc = 0; m_led = 0; end
               default: begin
                  if (hq.size() > 0) begin m_acc = hq.pop_back(); m_led = 0; end
               end
            endcase
         end
         h3 = h2; h2 = h1; h1 = bus.push;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [3:0] ea;
         ea = 4'(m_acc);
         chk("acc",        int'(bus.acc),        int'(ea));
         chk("neg",        int'(bus.neg),        (m_acc < 0) ? 1 : 0);
         chk("mag",        int'(bus.mag),        (m_acc < 0) ? -m_acc : m_acc);
         chk("led",        int'(bus.led),        int'(m_led));
         chk("done",       int'(bus.done),       int'(m_done));
         chk("hist_empty", int'(bus.hist_empty), (hq.size() == 0) ? 1 : 0);
         chk("hist_full",  int'(bus.hist_full),  (hq.size() == D) ? 1 : 0);
      end
   end

   task automatic do_reset();
      @(negedge clk); #1;
      reset_n = 1'b0; bus.push = 1'b0;
      @(negedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_op(input logic [1:0] o, input logic [3:0] v);
      int pulses;
      pulses = 0;
      @(negedge clk); #1;
      bus.op = o; bus.in = v; bus.push = 1'b1;
      repeat (4) begin @(negedge clk); if (bus.done) pulses++; end
      #1 bus.push = 1'b0;
      repeat (2) begin @(negedge clk); if (bus.done) pulses++; end
      chk("done_pulses", pulses, 1);
   endtask

   initial begin
      int pulses;
      bus.push = 1'b0; bus.op = 2'b00; bus.in = 4'h0;
      #2 reset_n = 1'b0;
      #20 reset_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_acc", int'(bus.acc), 0);
      chk("rst_neg", int'(bus.neg), 0);
      chk("rst_mag", int'(bus.mag), 0);
      chk("rst_led", int'(bus.led), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_empty", int'(bus.hist_empty), 1);

      do_op(2'b00, 4'd3);
      chk("add3_acc", int'(bus.acc), 3);
      chk("add3_led", int'(bus.led), 0);
      do_op(2'b00, 4'd6);
`ifdef SATURATE_EN
      chk("add6_acc", int'(bus.acc), 7);
`else
      chk("add6_acc", int'(bus.acc), 9);
      chk("add6_neg", int'(bus.neg), 1);
      chk("add6_mag", int'(bus.mag), 7);
`endif
      chk("add6_led", int'(bus.led), 1);

      do_op(2'b10, 4'd0);
      do_op(2'b01, 4'd1);
      chk("sub1_acc", int'(bus.acc), 15);
      chk("sub1_mag", int'(bus.mag), 1);
      chk("sub1_led", int'(bus.led), 0);
      do_op(2'b10, 4'd0);
      do_op(2'b01, 4'b1000);
`ifdef SATURATE_EN
      chk("subm_acc", int'(bus.acc), 7);
`else
      chk("subm_acc", int'(bus.acc), 8);
      chk("subm_mag", int'(bus.mag), 8);
`endif
      chk("subm_led", int'(bus.led), 1);

      do_reset();
      do_op(2'b00, 4'd1); do_op(2'b00, 4'd2); do_op(2'b00, 4'd3);
      chk("adds_acc", int'(bus.acc), 6);
      do_op(2'b11, 4'd0); chk("undo1", int'(bus.acc), 3);
      do_op(2'b11, 4'd0); chk("undo2", int'(bus.acc), 1);
      do_op(2'b11, 4'd0); chk("undo3", int'(bus.acc), 0);
      do_op(2'b11, 4'd0); chk("undo4", int'(bus.acc), 0);
      chk("undo4_empty", int'(bus.hist_empty), 1);

      do_reset();
      repeat (5) do_op(2'b00, 4'd1);
      chk("add5_acc", int'(bus.acc), 5);
      chk("add5_full", int'(bus.hist_full), 1);
      do_op(2'b11, 4'd0); chk("u5_1", int'(bus.acc), 4);
      do_op(2'b11, 4'd0); chk("u5_2", int'(bus.acc), 3);
      do_op(2'b11, 4'd0); chk("u5_3", int'(bus.acc), 2);
      do_op(2'b11, 4'd0); chk("u5_4", int'(bus.acc), 1);
      do_op(2'b11, 4'd0); chk("u5_5", int'(bus.acc), 1);

      // Held push must commit exactly once.
      pulses = 0;
      @(negedge clk); #1;
      bus.op = 2'b00; bus.in = 4'd2; bus.push = 1'b1;
      repeat (20) begin @(negedge clk); if (bus.done) pulses++; end
      #1 bus.push = 1'b0;
      repeat (3) begin @(negedge clk); if (bus.done) pulses++; end
      chk("hold_pulses", pulses, 1);
      chk("hold_acc", int'(bus.acc), 3);

      // Reset while a commit is in flight: nothing commits.
      pulses = 0;
      @(negedge clk); #1;
      bus.push = 1'b1;
      @(negedge clk); #1;
      reset_n = 1'b0; bus.push = 1'b0;
      @(negedge clk); #1;
      reset_n = 1'b1;
      repeat (4) begin @(negedge clk); if (bus.done) pulses++; end
      chk("midrst_pulses", pulses, 0);
      chk("midrst_acc", int'(bus.acc), 0);
      chk("midrst_led", int'(bus.led), 0);
      chk("midrst_empty", int'(bus.hist_empty), 1);

      // Random traffic against the model, with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk); #1;
         bus.op = 2'($urandom);
         bus.in = 4'($urandom);
         if ($urandom_range(0, 2) == 0) bus.push = ~bus.push;
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
